// File: rtl/i2c_master.sv
// Single-transaction I2C initiator: START, {chip_id, wr1rd0}, reg_addr, one data byte
// (write, or read with master NACK), STOP.
module i2c_master #(
    parameter int unsigned CLK_DIV   = 4,
    parameter bit          CHECK_ACK = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [6:0] chip_id,
    input  logic       wr1rd0,
    input  logic [7:0] reg_addr,
    input  logic [7:0] wr_data,
    output logic [7:0] rd_data,
    output logic       busy,
    output logic       done,
    output logic       ack_err,
    output logic       SCL,
    inout  wire        SDA
);

    localparam int unsigned     QW    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [QW-1:0]   QLast = QW'(CLK_DIV - 1);

    localparam logic [3:0] StIdle  = 4'd0;
    localparam logic [3:0] StStart = 4'd1;
    localparam logic [3:0] StAddr  = 4'd2;
    localparam logic [3:0] StAckA  = 4'd3;
    localparam logic [3:0] StReg   = 4'd4;
    localparam logic [3:0] StAckR  = 4'd5;
    localparam logic [3:0] StWdata = 4'd6;
    localparam logic [3:0] StAckW  = 4'd7;
    localparam logic [3:0] StRdata = 4'd8;
    localparam logic [3:0] StMnack = 4'd9;
    localparam logic [3:0] StStop  = 4'd10;

    logic [3:0]    state_q, state_d;
    logic [QW-1:0] qcnt_q, qcnt_d;
    logic [1:0]    phase_q, phase_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    tx_q, tx_d;
    logic [7:0]    rx_q, rx_d;
    logic [7:0]    reg_q, reg_d;
    logic [7:0]    wdat_q, wdat_d;
    logic          wr_q, wr_d;
    logic          samp_q, samp_d;
    logic          ack_err_q, ack_err_d;
    logic [7:0]    rd_data_q, rd_data_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          scl_q, scl_d;
    logic          oe_q, oe_d;

    logic sda_in;
    logic q_last;
    logic sample_pt;
    logic slot_end;
    logic abort;

    assign SDA     = oe_q ? 1'b0 : 1'bz;
    assign sda_in  = SDA;
    assign SCL     = scl_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign ack_err = ack_err_q;
    assign rd_data = rd_data_q;

    assign q_last    = (qcnt_q == QLast);
    assign sample_pt = q_last && (phase_q == 2'd2);
    assign slot_end  = q_last && (phase_q == 2'd3);
    // samp_q holds the SDA value captured at the end of p2 of the current slot
    assign abort     = CHECK_ACK && samp_q;

    always_comb begin
        state_d   = state_q;
        qcnt_d    = qcnt_q;
        phase_d   = phase_q;
        bit_d     = bit_q;
        tx_d      = tx_q;
        rx_d      = rx_q;
        reg_d     = reg_q;
        wdat_d    = wdat_q;
        wr_d      = wr_q;
        samp_d    = samp_q;
        ack_err_d = ack_err_q;
        rd_data_d = rd_data_q;
        busy_d    = busy_q;
        done_d    = 1'b0;

        if (state_q != StIdle) begin
            qcnt_d = q_last ? '0 : qcnt_q + QW'(1);
            if (q_last) begin
                phase_d = phase_q + 2'd1;
            end
        end

        if (sample_pt) begin
            samp_d = sda_in;
            if (state_q == StRdata) begin
                rx_d = {rx_q[6:0], sda_in};
            end
            if ((state_q == StAckA || state_q == StAckR || state_q == StAckW) && sda_in) begin
                ack_err_d = 1'b1;
            end
        end

        case (state_q)
            StIdle: begin
                if (start) begin
                    state_d   = StStart;
                    tx_d      = {chip_id, wr1rd0};
                    reg_d     = reg_addr;
                    wdat_d    = wr_data;
                    wr_d      = wr1rd0;
                    rx_d      = 8'h00;
                    ack_err_d = 1'b0;
                    busy_d    = 1'b1;
                    qcnt_d    = '0;
                    phase_d   = 2'd0;
                    bit_d     = 3'd7;
                end
            end
            StStart: begin
                if (slot_end) begin
                    state_d = StAddr;
                end
            end
            StAddr, StReg, StWdata, StRdata: begin
                if (slot_end) begin
                    tx_d  = {tx_q[6:0], 1'b0};
                    bit_d = bit_q - 3'd1;
                    if (bit_q == 3'd0) begin
                        case (state_q)
                            StAddr:  state_d = StAckA;
                            StReg:   state_d = StAckR;
                            StWdata: state_d = StAckW;
                            default: state_d = StMnack;
                        endcase
                    end
                end
            end
            StAckA: begin
                if (slot_end) begin
                    if (abort) begin
                        state_d = StStop;
                    end else begin
                        state_d = StReg;
                        tx_d    = reg_q;
                    end
                end
            end
            StAckR: begin
                if (slot_end) begin
                    if (abort) begin
                        state_d = StStop;
                    end else if (wr_q) begin
                        state_d = StWdata;
                        tx_d    = wdat_q;
                    end else begin
                        state_d = StRdata;
                    end
                end
            end
            StAckW, StMnack: begin
                if (slot_end) begin
                    state_d = StStop;
                end
            end
            StStop: begin
                if (slot_end) begin
                    state_d = StIdle;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    if (!wr_q) begin
                        rd_data_d = rx_q;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Pin levels are registered from the next state/phase so SCL and SDA never glitch
    always_comb begin
        scl_d = 1'b1;
        oe_d  = 1'b0;
        case (state_d)
            StStart: begin
                scl_d = (phase_d != 2'd3);
                oe_d  = phase_d[1];
            end
            StAddr, StReg, StWdata: begin
                scl_d = (phase_d == 2'd1) || (phase_d == 2'd2);
                oe_d  = ~tx_d[7];
            end
            StAckA, StAckR, StAckW, StRdata, StMnack: begin
                scl_d = (phase_d == 2'd1) || (phase_d == 2'd2);
            end
            StStop: begin
                scl_d = (phase_d != 2'd0);
                oe_d  = ~phase_d[1];
            end
            default: begin
                scl_d = 1'b1;
                oe_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            qcnt_q    <= '0;
            phase_q   <= 2'd0;
            bit_q     <= 3'd7;
            tx_q      <= 8'h00;
            rx_q      <= 8'h00;
            reg_q     <= 8'h00;
            wdat_q    <= 8'h00;
            wr_q      <= 1'b0;
            samp_q    <= 1'b0;
            ack_err_q <= 1'b0;
            rd_data_q <= 8'h00;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            scl_q     <= 1'b1;
            oe_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            qcnt_q    <= qcnt_d;
            phase_q   <= phase_d;
            bit_q     <= bit_d;
            tx_q      <= tx_d;
            rx_q      <= rx_d;
            reg_q     <= reg_d;
            wdat_q    <= wdat_d;
            wr_q      <= wr_d;
            samp_q    <= samp_d;
            ack_err_q <= ack_err_d;
            rd_data_q <= rd_data_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            scl_q     <= scl_d;
            oe_q      <= oe_d;
        end
    end

endmodule

// File: tb/tb_i2c_master.sv
// Bench for i2c_master: two instances (CHECK_ACK=1 and 0) on separate buses, each with a
// register-target responder that answers address 0x50 and returns 0x3C on reads.
`timescale 1ns/1ps
module tb_i2c_master;

    localparam int unsigned CLK_DIV = 4;
    localparam int          SLOT    = 4 * CLK_DIV;
    localparam logic [6:0]  RESP_ID = 7'h50;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [6:0] chip_id;
    logic       wr1rd0;
    logic [7:0] reg_addr;
    logic [7:0] wr_data;
    logic [7:0] rd_data [2];
    logic       busy    [2];
    logic       done    [2];
    logic       ack_err [2];
    logic       scl     [2];
    wire        sda0;
    wire        sda1;
    logic       resp_low [2];
    logic [7:0] resp_rd;

    pullup (sda0);
    pullup (sda1);
    assign sda0 = resp_low[0] ? 1'b0 : 1'bz;
    assign sda1 = resp_low[1] ? 1'b0 : 1'bz;

    always #5 clk = ~clk;

    i2c_master #(.CLK_DIV(CLK_DIV), .CHECK_ACK(1'b1)) u_dut_chk (
        .clk(clk), .rst_n(rst_n), .start(start), .chip_id(chip_id), .wr1rd0(wr1rd0),
        .reg_addr(reg_addr), .wr_data(wr_data), .rd_data(rd_data[0]), .busy(busy[0]),
        .done(done[0]), .ack_err(ack_err[0]), .SCL(scl[0]), .SDA(sda0)
    );

    i2c_master #(.CLK_DIV(CLK_DIV), .CHECK_ACK(1'b0)) u_dut_nochk (
        .clk(clk), .rst_n(rst_n), .start(start), .chip_id(chip_id), .wr1rd0(wr1rd0),
        .reg_addr(reg_addr), .wr_data(wr_data), .rd_data(rd_data[1]), .busy(busy[1]),
        .done(done[1]), .ack_err(ack_err[1]), .SCL(scl[1]), .SDA(sda1)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Bus log entries: 0x100 START, 0x200 STOP, 0x300|bit for the ninth (ack) bit, else a byte
    int         log_q   [2][16];
    int         log_len [2];
    logic       prev_scl [2];
    logic       prev_sda [2];
    bit         r_active [2];
    int         r_pos    [2];
    int         r_byte   [2];
    logic [7:0] r_sh     [2];
    bit         r_addr_ok[2];
    bit         r_wr     [2];

    task automatic log_ev(input int b, input int v);
        if (log_len[b] < 16) log_q[b][log_len[b]] = v;
        log_len[b]++;
    endtask

    task automatic resp_step(input int b, input logic sv, input logic dv);
        if (!rst_n) begin
            r_active[b] = 0;
            resp_low[b] = 1'b0;
        end else if (sv && prev_scl[b] && prev_sda[b] && !dv) begin
            log_ev(b, 'h100);
            r_active[b] = 1;
            r_pos[b]    = -1;
            r_byte[b]   = 0;
            resp_low[b] = 1'b0;
        end else if (sv && prev_scl[b] && !prev_sda[b] && dv) begin
            log_ev(b, 'h200);
            r_active[b] = 0;
            resp_low[b] = 1'b0;
        end else if (r_active[b] && sv && !prev_scl[b]) begin
            if (r_pos[b] == 8) log_ev(b, 'h300 | int'(dv));
            else r_sh[b] = {r_sh[b][6:0], dv};
        end else if (r_active[b] && !sv && prev_scl[b]) begin
            if (r_pos[b] == 7) begin
                log_ev(b, int'(r_sh[b]));
                if (r_byte[b] == 0) begin
                    r_addr_ok[b] = (r_sh[b][7:1] == RESP_ID);
                    r_wr[b]      = r_sh[b][0];
                end
                resp_low[b] = r_addr_ok[b] && (r_byte[b] < 2 || r_wr[b]);
                r_pos[b]    = 8;
            end else begin
                if (r_pos[b] == 8) begin
                    r_pos[b]  = 0;
                    r_byte[b] = r_byte[b] + 1;
                end else begin
                    r_pos[b] = r_pos[b] + 1;
                end
                resp_low[b] = (r_byte[b] == 2 && !r_wr[b] && r_addr_ok[b] && r_pos[b] >= 0)
                              ? !resp_rd[7 - r_pos[b]] : 1'b0;
            end
        end
        prev_scl[b] = sv;
        prev_sda[b] = dv;
    endtask

    always @(negedge clk) begin
        resp_step(0, scl[0], sda0);
        resp_step(1, scl[1], sda1);
    end

    // Transaction-level model: latency, busy/done windows and result registers per instance
    int         cyc = 0;
    bit         m_active  [2];
    bit         m_done    [2];
    int         m_acc     [2];
    int         m_lat     [2];
    logic [7:0] m_rd      [2];
    logic [7:0] m_pend_rd [2];
    logic       m_err     [2];
    logic       m_pend_err[2];
    logic       m_wr      [2];
    int         lat_meas  [2];
    int         n_done    [2];

    always @(posedge clk) begin : model
        bit acc;
        bit nack;
        bit abrt;
        int slots;
        cyc = cyc + 1;
        for (int b = 0; b < 2; b++) begin
            if (!rst_n) begin
                m_active[b] = 0;
                m_done[b]   = 0;
                m_rd[b]     = 8'h00;
                m_err[b]    = 1'b0;
            end else begin
                acc       = start && !m_active[b];
                m_done[b] = 0;
                if (m_active[b] && (cyc - m_acc[b] == m_lat[b])) begin
                    m_active[b] = 0;
                    m_done[b]   = 1;
                    m_err[b]    = m_pend_err[b];
                    if (!m_wr[b]) m_rd[b] = m_pend_rd[b];
                end
                if (acc) begin
                    nack  = (chip_id != RESP_ID);
                    abrt  = nack && (b == 0);
                    // start + address byte & ack + (reg, data bytes & acks) + stop
                    slots = 1 + 9 + (abrt ? 0 : 18) + 1;
                    m_lat[b]      = slots * 4 * int'(CLK_DIV);
                    m_wr[b]       = wr1rd0;
                    m_pend_err[b] = nack;
                    m_pend_rd[b]  = !nack ? resp_rd : (abrt ? 8'h00 : 8'hFF);
                    m_active[b]   = 1;
                    m_acc[b]      = cyc;
                    m_err[b]      = 1'b0;
                end
            end
        end
    end

    always @(negedge clk) begin
        for (int b = 0; b < 2; b++) begin
            if (!rst_n) begin
                check($sformatf("rst_done[%0d]", b), done[b], 1'b0);
                check($sformatf("rst_busy[%0d]", b), busy[b], 1'b0);
                check($sformatf("rst_scl[%0d]", b), scl[b], 1'b1);
            end else begin
                check($sformatf("busy[%0d]", b), busy[b], m_active[b]);
                check($sformatf("done[%0d]", b), done[b], m_done[b]);
                check($sformatf("rd_data[%0d]", b), rd_data[b], m_rd[b]);
                if (!m_active[b]) begin
                    check($sformatf("ack_err[%0d]", b), ack_err[b], m_err[b]);
                    check($sformatf("idle_scl[%0d]", b), scl[b], 1'b1);
                end
                if (done[b] === 1'b1) begin
                    n_done[b]++;
                    lat_meas[b] = cyc - m_acc[b];
                end
            end
        end
    end

    task automatic check_bus(input int b, input logic [6:0] id, input logic wr,
                             input logic [7:0] rg, input logic [7:0] dat);
        int  exp [10];
        int  n;
        bit  nack;
        int  a;
        nack   = (id != RESP_ID);
        a      = nack ? 'h301 : 'h300;
        exp[0] = 'h100;
        exp[1] = int'({id, wr});
        exp[2] = a;
        n      = 3;
        if (!(nack && b == 0)) begin
            exp[3] = int'(rg);
            exp[4] = a;
            exp[5] = wr ? int'(dat) : (nack ? 'hFF : int'(resp_rd));
            exp[6] = wr ? a : 'h301;
            n      = 7;
        end
        exp[n] = 'h200;
        n++;
        check($sformatf("bus_len[%0d]", b), log_len[b], n);
        for (int i = 0; i < n && i < log_len[b]; i++) begin
            check($sformatf("bus[%0d][%0d]", b, i), log_q[b][i], exp[i]);
        end
    endtask

    task automatic run_txn(input logic [6:0] id, input logic wr, input logic [7:0] rg,
                           input logic [7:0] dat, input int retrig);
        int nd [2];
        bit finished;
        @(negedge clk);
        for (int b = 0; b < 2; b++) begin
            log_len[b]  = 0;
            nd[b]       = n_done[b];
            lat_meas[b] = -1;
        end
        chip_id  = id;
        wr1rd0   = wr;
        reg_addr = rg;
        wr_data  = dat;
        start    = 1'b1;
        @(negedge clk);
        start    = 1'b0;
        finished = 0;
        for (int i = 1; i < 4000 && !finished; i++) begin
            @(negedge clk);
            start = (i == retrig);
            if (!m_active[0] && !m_active[1]) finished = 1;
        end
        start = 1'b0;
        check("txn_complete", finished, 1'b1);
        repeat (4) @(negedge clk);
        for (int b = 0; b < 2; b++) begin
            check($sformatf("done_pulses[%0d]", b), n_done[b] - nd[b], 1);
            check_bus(b, id, wr, rg, dat);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst_n    = 1'b0;
        start    = 1'b0;
        chip_id  = 7'h00;
        wr1rd0   = 1'b0;
        reg_addr = 8'h00;
        wr_data  = 8'h00;
        resp_rd  = 8'h3C;
        for (int b = 0; b < 2; b++) begin
            resp_low[b] = 1'b0;
            prev_scl[b] = 1'b1;
            prev_sda[b] = 1'b1;
            r_active[b] = 0;
            r_pos[b]    = 0;
            r_byte[b]   = 0;
            r_sh[b]     = 8'h00;
            r_addr_ok[b] = 0;
            r_wr[b]     = 0;
            log_len[b]  = 0;
            m_active[b] = 0;
            m_done[b]   = 0;
            m_acc[b]    = 0;
            m_lat[b]    = 0;
            m_rd[b]     = 8'h00;
            m_err[b]    = 1'b0;
            n_done[b]   = 0;
            lat_meas[b] = -1;
        end

        repeat (3) @(negedge clk);
        check("reset_busy", busy[0], 1'b0);
        check("reset_done", done[0], 1'b0);
        check("reset_ack_err", ack_err[0], 1'b0);
        check("reset_rd_data", rd_data[0], 8'h00);
        check("reset_scl", scl[0], 1'b1);
        check("reset_sda", sda0, 1'b1);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        run_txn(7'h50, 1'b1, 8'h12, 8'hA5, -1);
        check("wr_latency", lat_meas[0], 464);
        check("wr_addr_byte", log_q[0][1], 'hA1);
        check("wr_data_byte", log_q[0][5], 'hA5);
        check("wr_ack_err", ack_err[0], 1'b0);

        run_txn(7'h50, 1'b1, 8'h12, 8'hA5, 50);
        check("retrig_latency", lat_meas[0], 464);

        run_txn(7'h50, 1'b0, 8'h34, 8'h00, -1);
        check("rd_latency", lat_meas[0], 464);
        check("rd_addr_byte", log_q[0][1], 'hA0);
        check("rd_result", rd_data[0], 8'h3C);
        check("rd_mnack", log_q[0][6], 'h301);

        run_txn(7'h51, 1'b1, 8'h12, 8'hA5, -1);
        check("nack_abort_latency", lat_meas[0], 176);
        check("nack_abort_ack_err", ack_err[0], 1'b1);
        check("nack_abort_stop", log_q[0][3], 'h200);
        check("nack_cont_latency", lat_meas[1], 464);
        check("nack_cont_ack_err", ack_err[1], 1'b1);

        // Reset while the register byte is being driven (reg bit 4 of 0x00, SCL low, SDA low)
        @(negedge clk);
        log_len[0] = 0;
        log_len[1] = 0;
        chip_id  = 7'h50;
        wr1rd0   = 1'b1;
        reg_addr = 8'h00;
        wr_data  = 8'hFF;
        start    = 1'b1;
        @(negedge clk);
        start    = 1'b0;
        repeat (13 * SLOT + 2) @(negedge clk);
        check("pre_reset_scl", scl[0], 1'b0);
        check("pre_reset_sda", sda0, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        check("async_reset_scl", scl[0], 1'b1);
        check("async_reset_sda", sda0, 1'b1);
        check("async_reset_busy", busy[0], 1'b0);
        check("async_reset_scl_nochk", scl[1], 1'b1);
        check("async_reset_sda_nochk", sda1, 1'b1);
        repeat (2) @(negedge clk);
        check("reset_clears_rd_data", rd_data[0], 8'h00);
        check("reset_clears_ack_err", ack_err[1], 1'b0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        run_txn(7'h50, 1'b0, 8'h34, 8'h00, -1);
        check("post_reset_latency", lat_meas[0], 464);
        check("post_reset_rd_result", rd_data[0], 8'h3C);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
